sram_axi_bridge: RTL

Responder for the single-port sram-like bus that the instruction and data caches drive on their memory side (req/addr_ok/data_ok). Converts each accepted request into one AXI3 single-beat read (AR/R) or write (AW/W/B) transaction. Sits between a cache's miss/refill port and the SoC AXI crossbar. One outstanding transaction at a time.

---
 rtl/sram_axi_pkg.sv | 24 ++
 rtl/sram_axi_bridge_if.sv | 81 ++++++++
 rtl/sram_axi_wstrb.sv | 19 +
 rtl/sram_axi_bridge.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/sram_axi_pkg.sv
// Shared types and constants for the sram-like to AXI3 bridge.
package sram_axi_pkg;

    // RD is only reachable when the registered read-data option is built in.
    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        AW,
        B,
        RD
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_LEN_ZERO   = 4'd0;
    localparam logic [1:0] AXI_LOCK_ZERO  = 2'd0;
    localparam logic [3:0] AXI_CACHE_ZERO = 4'd0;
    localparam logic [2:0] AXI_PROT_ZERO  = 3'd0;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/sram_axi_bridge_if.sv
// Bundle of the sram-like request bus and the AXI3 master bus around the bridge.
// The master modport is the bridge's view (it masters AXI); slave is the surroundings.
interface sram_axi_bridge_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata_axi;
    logic        rvalid;
    logic        rlast;
    logic [1:0]  rresp;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata_axi;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;

    modport master (
        input  req, wr, size, addr, wdata,
        output rdata, addr_ok, data_ok,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rdata_axi, rvalid, rlast, rresp,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata_axi, wstrb, wlast, wvalid,
        input  wready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        output req, wr, size, addr, wdata,
        input  rdata, addr_ok, data_ok,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rdata_axi, rvalid, rlast, rresp,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata_axi, wstrb, wlast, wvalid,
        output wready,
        output bvalid, bresp,
        input  bready
    );
endinterface

// File: rtl/sram_axi_wstrb.sv
// Byte-lane write strobe from transfer size and the low address bits.
module sram_axi_wstrb
    import sram_axi_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] wstrb
);
    // size 3 is not a legal sram-like size; it yields an empty strobe.
    always_comb begin
        wstrb = 4'b0000;
        case (size)
            SIZE_B:  wstrb = 4'b0001 << addr_lo;
            SIZE_H:  wstrb = 4'b0011 << {addr_lo[1], 1'b0};
            SIZE_W:  wstrb = 4'b1111;
            default: wstrb = 4'b0000;
        endcase
    end
endmodule

// File: rtl/sram_axi_bridge.sv
// sram-like responder issuing one single-beat AXI3 read or write per request.
// SRAM_AXI_RDATA_REG_EN: register the R beat and return data_ok/rdata one cycle later.
module sram_axi_bridge
    import sram_axi_pkg::*;
#(
    parameter logic [3:0] ID = 4'd0
) (
    input logic clk,
    input logic resetn,
    sram_axi_bridge_if.master bus
);
    state_e      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic [3:0]  wstrb_q;
    logic [3:0]  wstrb_c;
    logic        aw_done;
    logic        w_done;
    logic        arvalid_q;
    logic        rready_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;
    logic        aw_hs;
    logic        w_hs;
    logic        r_hs;
    logic        b_hs;
`ifdef SRAM_AXI_RDATA_REG_EN
    logic [31:0] rdata_q;
`endif

    sram_axi_wstrb u_wstrb (
        .size    (bus.size),
        .addr_lo (bus.addr[1:0]),
        .wstrb   (wstrb_c)
    );

    assign aw_hs = awvalid_q && bus.awready;
    assign w_hs  = wvalid_q && bus.wready;
    assign r_hs  = rready_q && bus.rvalid;
    assign b_hs  = bready_q && bus.bvalid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            wstrb_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
`ifdef SRAM_AXI_RDATA_REG_EN
            rdata_q   <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.req) begin
                    addr_q  <= bus.addr;
                    wdata_q <= bus.wdata;
                    size_q  <= bus.size;
                    wstrb_q <= wstrb_c;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (bus.wr) begin
                        state     <= AW;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                    end else begin
                        state     <= AR;
                        arvalid_q <= 1'b1;
                    end
                end
                AR: if (bus.arready) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state     <= R;
                end
                R: if (bus.rvalid) begin
                    rready_q <= 1'b0;
`ifdef SRAM_AXI_RDATA_REG_EN
                    rdata_q  <= bus.rdata_axi;
                    state    <= RD;
`else
                    state    <= IDLE;
`endif
                end
                RD: state <= IDLE;
                AW: begin
                    // AW and W complete independently; B waits for both.
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        bready_q <= 1'b1;
                        state    <= B;
                    end
                end
                B: if (bus.bvalid) begin
                    bready_q <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.addr_ok = bus.req && (state == IDLE);
`ifdef SRAM_AXI_RDATA_REG_EN
    assign bus.data_ok = (state == RD) || b_hs;
    assign bus.rdata   = rdata_q;
`else
    assign bus.data_ok = r_hs || b_hs;
    assign bus.rdata   = r_hs ? bus.rdata_axi : 32'd0;
`endif

    assign bus.arid      = ID;
    assign bus.araddr    = addr_q;
    assign bus.arlen     = AXI_LEN_ZERO;
    assign bus.arsize    = {1'b0, size_q};
    assign bus.arburst   = AXI_BURST_INCR;
    assign bus.arlock    = AXI_LOCK_ZERO;
    assign bus.arcache   = AXI_CACHE_ZERO;
    assign bus.arprot    = AXI_PROT_ZERO;
    assign bus.arvalid   = arvalid_q;
    assign bus.rready    = rready_q;

    assign bus.awid      = ID;
    assign bus.awaddr    = addr_q;
    assign bus.awlen     = AXI_LEN_ZERO;
    assign bus.awsize    = {1'b0, size_q};
    assign bus.awburst   = AXI_BURST_INCR;
    assign bus.awlock    = AXI_LOCK_ZERO;
    assign bus.awcache   = AXI_CACHE_ZERO;
    assign bus.awprot    = AXI_PROT_ZERO;
    assign bus.awvalid   = awvalid_q;

    assign bus.wid       = ID;
    assign bus.wdata_axi = wdata_q;
    assign bus.wstrb     = wstrb_q;
    assign bus.wlast     = wvalid_q;
    assign bus.wvalid    = wvalid_q;
    assign bus.bready    = bready_q;

    // Response status and rlast carry nothing for single-beat OKAY-agnostic traffic.
    logic unused_resp;
    assign unused_resp = ^{bus.rlast, bus.rresp, bus.bresp};
endmodule
